lvds_lane_aligner: RTL and testbench

- Automatic word-alignment sequencer for one Python camera LVDS receiver: 5 lanes x 8 bits (lane 4 = sync, lanes 0-3 = data).
- Runs in the camera rx clock domain, between the LVDS deserializer and the python decoder.
- While the sensor sends its training word, issues single-cycle bitslip pulses on rxd_align per lane until each lane shows the training word stably.
- Replaces the software-driven align register flow with a start/done handshake.

---
 rtl/lvds_lane_aligner.sv | 220 ++++++++++++++++++++++
 tb/tb_lvds_lane_aligner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_lane_aligner.sv
// Word-alignment sequencer for one Python camera LVDS receiver (4 data lanes + sync lane).
// Optional statistics outputs (slip_log, align_cycles) are built when LVDS_LANE_ALIGNER_STATS_EN is defined.
module lvds_lane_aligner #(
  parameter logic [7:0]  TRAIN_WORD = 8'hE9,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MATCH_CNT  = 32,
  parameter int unsigned MAX_SLIPS  = 8
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_locked,
  input  logic [39:0] rxd,
  output logic [4:0]  rxd_align,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [4:0]  lane_ok
`ifdef LVDS_LANE_ALIGNER_STATS_EN
  ,
  output logic [19:0] slip_log,
  output logic [23:0] align_cycles
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_NEXT
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CNT - 1);
  localparam logic [3:0] SLIP_LIMIT  = 4'(MAX_SLIPS);
  localparam logic [2:0] LAST_LANE   = 3'd4;

  state_e      state_q;
  logic [2:0]  lane_q;
  logic [7:0]  settle_q;
  logic [7:0]  match_q;
  logic [3:0]  slip_q;
  logic [4:0]  rxd_align_q;
  logic [4:0]  lane_ok_q;
  logic        busy_q;
  logic        done_q;
  logic        fail_q;

  logic        start_meta_q;
  logic        start_sync_q;
  logic        start_prev_q;
  logic        lock_meta_q;
  logic        lock_sync_q;

  logic        start_rise;
  logic        start_go;
  logic        lock_lost;
  logic [4:0]  lane_bit;
  logic [7:0]  lane_word;

  assign start_rise = start_sync_q & ~start_prev_q;
  assign start_go   = (state_q == ST_IDLE) && start_rise;
  assign lock_lost  = (state_q != ST_IDLE) && !lock_sync_q;
  assign lane_bit   = 5'b00001 << lane_q;

  always_comb begin
    lane_word = rxd[39:32];
    case (lane_q)
      3'd0:    lane_word = rxd[7:0];
      3'd1:    lane_word = rxd[15:8];
      3'd2:    lane_word = rxd[23:16];
      3'd3:    lane_word = rxd[31:24];
      default: lane_word = rxd[39:32];
    endcase
  end

  // NOTE: every register here is updated with <= so all of them sample pre-edge values
  // consistently; a blocking assignment would let later lines see half-updated state.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      state_q      <= ST_IDLE;
      lane_q       <= 3'd0;
      settle_q     <= 8'd0;
      match_q      <= 8'd0;
      slip_q       <= 4'd0;
      rxd_align_q  <= 5'd0;
      lane_ok_q    <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      lock_meta_q  <= rx_locked;
      lock_sync_q  <= lock_meta_q;

      // The bitslip strobe defaults low so it can only ever last the single SLIP cycle.
      rxd_align_q  <= 5'd0;

      if (lock_lost) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        fail_q    <= 1'b1;
        lane_ok_q <= 5'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_rise) begin
              state_q   <= ST_SETTLE;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              fail_q    <= 1'b0;
              lane_ok_q <= 5'd0;
              lane_q    <= 3'd0;
              slip_q    <= 4'd0;
              settle_q  <= 8'd0;
              match_q   <= 8'd0;
            end
          end

          ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
              state_q  <= ST_CHECK;
              settle_q <= 8'd0;
              match_q  <= 8'd0;
            end else begin
              settle_q <= settle_q + 8'd1;
            end
          end

          ST_CHECK: begin
            if (lane_word == TRAIN_WORD) begin
              if (match_q == MATCH_LAST) begin
                lane_ok_q <= lane_ok_q | lane_bit;
                state_q   <= ST_NEXT;
              end else begin
                match_q <= match_q + 8'd1;
              end
            end else if (slip_q == SLIP_LIMIT) begin
              fail_q  <= 1'b1;
              state_q <= ST_NEXT;
            end else begin
              rxd_align_q <= lane_bit;
              state_q     <= ST_SLIP;
            end
          end

          ST_SLIP: begin
            slip_q   <= slip_q + 4'd1;
            settle_q <= 8'd0;
            state_q  <= ST_SETTLE;
          end

          ST_NEXT: begin
            if (lane_q == LAST_LANE) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              lane_q   <= lane_q + 3'd1;
              slip_q   <= 4'd0;
              settle_q <= 8'd0;
              state_q  <= ST_SETTLE;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rxd_align = rxd_align_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign lane_ok   = lane_ok_q;

`ifdef LVDS_LANE_ALIGNER_STATS_EN
  logic [19:0] slip_log_q;
  logic [23:0] cycles_q;

  // Slip counts are latched when a lane is finished (pass or give-up) in NEXT.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      slip_log_q <= 20'd0;
      cycles_q   <= 24'd0;
    end else if (start_go) begin
      slip_log_q <= 20'd0;
      cycles_q   <= 24'd0;
    end else begin
      if (busy_q && (cycles_q != 24'hFF_FFFF)) begin
        cycles_q <= cycles_q + 24'd1;
      end
      if ((state_q == ST_NEXT) && !lock_lost) begin
        for (int k = 0; k < 5; k++) begin
          if (lane_q == 3'(k)) begin
            slip_log_q[4*k +: 4] <= slip_q;
          end
        end
      end
    end
  end

  assign slip_log     = slip_log_q;
  assign align_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_lvds_lane_aligner.sv
// Directed bench for lvds_lane_aligner: a bitslip-aware receiver model feeds rxd, and a
// scoreboard queue holds the expected outcome of each alignment sequence until done rises.
`timescale 1ns/1ps
module tb_lvds_lane_aligner;

  localparam logic [7:0] TRAIN = 8'hE9;
  localparam int SETTLE   = 16;
  localparam int MATCH    = 32;
  localparam int SLIPS    = 8;
  // Two synchroniser flops plus the edge-detect register before IDLE reacts.
  localparam int SYNC_LAT = 3;
  localparam int SEQ_CYC  = 5 * (SETTLE + MATCH + 1);

  typedef struct packed {
    logic [4:0]      lane_ok;
    logic            fail;
    logic [4:0][3:0] pulses;
    logic [15:0]     cycles;
  } exp_t;

  logic        c = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rx_locked;
  logic [39:0] rxd;
  logic [4:0]  rxd_align;
  logic        busy;
  logic        done;
  logic        fail;
  logic [4:0]  lane_ok;
`ifdef LVDS_LANE_ALIGNER_STATS_EN
  logic [19:0] slip_log;
  logic [23:0] align_cycles;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pulse_cnt [5] = '{default: 0};
  int   slips     [5] = '{default: 0};
  int   offs      [5] = '{default: 0};
  logic dead      [5] = '{default: 1'b0};
  logic glitch = 1'b0;
  int   last_pulse = -1000;
  int   min_gap = 1000000;
  int   multi_hot = 0;
  int   c0 = 0;
  int   snap [5] = '{default: 0};
  exp_t sb[$];

  lvds_lane_aligner dut (
    .c         (c),
    .rst_n     (rst_n),
    .start     (start),
    .rx_locked (rx_locked),
    .rxd       (rxd),
    .rxd_align (rxd_align),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .lane_ok   (lane_ok)
`ifdef LVDS_LANE_ALIGNER_STATS_EN
    ,
    .slip_log     (slip_log),
    .align_cycles (align_cycles)
`endif
  );

  always #5 c = ~c;

  always @(posedge c) cyc <= cyc + 1;

  // Receiver model: each bitslip pulse rotates that lane by one bit, applied on the falling edge.
  always @(negedge c) begin
    if (rxd_align != 5'd0) begin
      if ($countones(rxd_align) != 1) multi_hot <= multi_hot + 1;
      if (cyc - last_pulse < min_gap) min_gap <= cyc - last_pulse;
      last_pulse <= cyc;
      for (int k = 0; k < 5; k++) begin
        if (rxd_align[k]) begin
          pulse_cnt[k] <= pulse_cnt[k] + 1;
          slips[k]     <= slips[k] + 1;
        end
      end
    end
  end

  function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
    logic [7:0] v;
    v = w;
    for (int i = 0; i < r; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  always_comb begin
    rxd = 40'd0;
    for (int k = 0; k < 5; k++) begin
      rxd[8*k +: 8] = dead[k] ? 8'h00 :
                      (rotl(TRAIN, (offs[k] + slips[k]) % 8) ^ ((glitch && k == 1) ? 8'hFF : 8'h00));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge c);
  endtask

  // Lane k will need exactly 'need' further slips to show the training word.
  task automatic set_need(input int k, input int need);
    offs[k] = (16 - (slips[k] % 8) - need) % 8;
  endtask

  task automatic kick();
    @(negedge c);
    start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 5; k++) snap[k] = pulse_cnt[k];
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (busy) begin ok = 1'b1; break; end
      @(negedge c);
    end
    check({tag, " busy-rise"}, int'(ok), 1);
    ok = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge c);
      if (done && !busy) begin ok = 1'b1; break; end
    end
    check({tag, " done"}, int'(ok), 1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard-empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, " lane_ok"}, int'(lane_ok), int'(e.lane_ok));
    check({tag, " fail"}, int'(fail), int'(e.fail));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s pulses lane%0d", tag, k), pulse_cnt[k] - snap[k], int'(e.pulses[k]));
    end
    if (e.cycles != 16'd0) check({tag, " latency"}, cyc - c0, int'(e.cycles));
  endtask

  function automatic exp_t mk_exp(input logic [4:0] ok, input logic f, input logic [15:0] cy);
    exp_t e;
    e = '0;
    e.lane_ok = ok;
    e.fail    = f;
    e.cycles  = cy;
    return e;
  endfunction

  initial begin
    exp_t e;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    rx_locked = 1'b1;
    for (int k = 0; k < 5; k++) set_need(k, 0);

    // Reset state
    tick(3);
    check("rst rxd_align", int'(rxd_align), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst fail", int'(fail), 0);
    check("rst lane_ok", int'(lane_ok), 0);
    rst_n = 1'b1;
    tick(5);

    // All lanes already aligned: no slips, fixed latency
    sb.push_back(mk_exp(5'h1F, 1'b0, 16'(SYNC_LAT + SEQ_CYC)));
    kick();
    wait_done("aligned");

    // Start held high after done must not retrigger
    tick(40);
    check("held-start busy", int'(busy), 0);
    check("held-start done", int'(done), 1);
    start = 1'b0;
    tick(5);

    // Lane k rotated so it needs k slips
    for (int k = 0; k < 5; k++) set_need(k, k);
    e = mk_exp(5'h1F, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++) e.pulses[k] = 4'(k);
    sb.push_back(e);
    kick();
    wait_done("rotated");
    start = 1'b0;
    tick(5);

    // Dead lane 2, plus a start edge while busy that must be ignored
    for (int k = 0; k < 5; k++) set_need(k, 0);
    dead[2] = 1'b1;
    e = mk_exp(5'h1B, 1'b1, 16'd0);
    e.pulses[2] = 4'(SLIPS);
    sb.push_back(e);
    kick();
    tick(100);
    start = 1'b0;
    tick(6);
    start = 1'b1;
    wait_done("dead-lane");
    tick(20);
    check("busy-edge no restart", int'(busy), 0);
    start = 1'b0;
    dead[2] = 1'b0;
    tick(5);

    // Lock loss during lane 3 CHECK
    for (int k = 0; k < 5; k++) set_need(k, 0);
    kick();
    tick(SYNC_LAT + 3 * (SETTLE + MATCH + 1) + SETTLE + 1 + 10);
    check("pre-lock-loss busy", int'(busy), 1);
    rx_locked = 1'b0;
    tick(3);
    check("lock-loss busy", int'(busy), 0);
    check("lock-loss done", int'(done), 1);
    check("lock-loss fail", int'(fail), 1);
    check("lock-loss lane_ok", int'(lane_ok), 0);
    for (int k = 0; k < 5; k++) snap[k] = pulse_cnt[k];
    tick(50);
    check("lock-loss no pulses", (pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4])
                                 - (snap[0] + snap[1] + snap[2] + snap[3] + snap[4]), 0);
    start = 1'b0;
    tick(5);

    // Start while unlocked aborts at once
    kick();
    tick(SYNC_LAT + 8);
    check("unlocked-start busy", int'(busy), 0);
    check("unlocked-start fail", int'(fail), 1);
    check("unlocked-start done", int'(done), 1);
    start = 1'b0;
    rx_locked = 1'b1;
    tick(5);

    // Clean pass after lock is restored
    sb.push_back(mk_exp(5'h1F, 1'b0, 16'(SYNC_LAT + SEQ_CYC)));
    kick();
    wait_done("relock");
    start = 1'b0;
    tick(5);

    // One-cycle glitch on lane 1 when its match count is 30
    for (int k = 0; k < 5; k++) set_need(k, 0);
    e = mk_exp(5'h1F, 1'b0, 16'd0);
    e.pulses[1] = 4'(SLIPS);
    sb.push_back(e);
    kick();
    tick(SYNC_LAT + (SETTLE + MATCH + 1) + SETTLE + 30 - 1);
    glitch = 1'b1;
    tick(1);
    glitch = 1'b0;
    wait_done("glitch");
    start = 1'b0;
    tick(5);

    // Asynchronous reset in the middle of a SLIP cycle
    dead[0] = 1'b1;
    kick();
    begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 500; t++) begin
        @(negedge c);
        if (rxd_align != 5'd0) begin seen = 1'b1; break; end
      end
      check("slip seen before reset", int'(seen), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("mid-slip rst rxd_align", int'(rxd_align), 0);
    check("mid-slip rst busy", int'(busy), 0);
    check("mid-slip rst done", int'(done), 0);
    check("mid-slip rst fail", int'(fail), 0);
    check("mid-slip rst lane_ok", int'(lane_ok), 0);
    start = 1'b0;
    dead[0] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("post-reset idle", int'(busy), 0);

    check("single-hot rxd_align", multi_hot, 0);
    check("pulse spacing >= 17", int'(min_gap >= SETTLE + 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
